// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: a CPU-writable shadow bank of tap coefficients that
// is streamed into a tap chain over a shared coefficient bus with a one-hot
// per-tap load strobe.
module fir_coef_loader #(
    parameter int H_N_WIDTH = 18,
    parameter int NUM_TAPS  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]        cfg_wr_addr,
    input  logic signed [H_N_WIDTH-1:0]        cfg_wr_data,
    input  logic                               load_start,
    output logic signed [H_N_WIDTH-1:0]        h_n_out,
    output logic [NUM_TAPS-1:0]                h_n_vld,
    output logic                               busy,
    output logic                               done,
    output logic                               wr_drop
);

    localparam int unsigned AW         = $clog2(NUM_TAPS);
    localparam int unsigned NUM_TAPS_U = NUM_TAPS;
    localparam logic [AW-1:0]       LAST_IDX = AW'(NUM_TAPS - 1);
    localparam logic [NUM_TAPS-1:0] VLD_ONE  = NUM_TAPS'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                       state;
    logic [AW-1:0]                idx;
    logic signed [H_N_WIDTH-1:0]  bank [NUM_TAPS];

    logic                         wr_addr_ok_c;
    logic                         wr_accept_c;
    logic signed [H_N_WIDTH-1:0]  first_coef_c;

    // Write qualification; the first strobe forwards a same-edge write to entry 0
    always_comb begin
        wr_addr_ok_c = (32'(cfg_wr_addr) < NUM_TAPS_U);
        wr_accept_c  = cfg_wr_en && (state == ST_IDLE) && wr_addr_ok_c;
        first_coef_c = (wr_accept_c && (cfg_wr_addr == '0)) ? cfg_wr_data : bank[0];
    end

    // Shadow bank: only written while idle and in range
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_accept_c) begin
            bank[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // Transfer FSM: strobe 0 is issued on the start edge, so idx holds the next tap
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            h_n_out <= '0;
            h_n_vld <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            h_n_out <= '0;
            h_n_vld <= '0;
            done    <= 1'b0;
            wr_drop <= cfg_wr_en && !wr_accept_c;

            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (load_start) begin
                        h_n_out <= first_coef_c;
                        h_n_vld <= VLD_ONE;
                        idx     <= AW'(1);
                        busy    <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    h_n_out <= bank[idx];
                    h_n_vld <= VLD_ONE << idx;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= ST_FINISH;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed testbench for fir_coef_loader with a 16-tap FIR chain model.
module tb_fir_coef_loader;

    localparam int W = 18;
    localparam int N = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_wr_en;
    logic [3:0]          cfg_wr_addr;
    logic signed [W-1:0] cfg_wr_data;
    logic                load_start;
    logic signed [W-1:0] h_n_out;
    logic [N-1:0]        h_n_vld;
    logic                busy;
    logic                done;
    logic                wr_drop;

    int checks = 0;
    int errors = 0;
    int exp_bank [N];

    // Tap chain model driven by the loader
    logic signed [W-1:0] tap_h [N] = '{default: '0};
    logic signed [W-1:0] x_dl  [N] = '{default: '0};
    logic signed [W-1:0] x_in  = '0;
    longint              y_n;

    fir_coef_loader #(.H_N_WIDTH(W), .NUM_TAPS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_wr_data (cfg_wr_data),
        .load_start  (load_start),
        .h_n_out     (h_n_out),
        .h_n_vld     (h_n_vld),
        .busy        (busy),
        .done        (done),
        .wr_drop     (wr_drop)
    );

    always #5 clk = ~clk;

    // Taps capture the bus on their strobe; x delay line shifts every cycle
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (h_n_vld[i]) tap_h[i] <= h_n_out;
        end
        x_dl[0] <= x_in;
        for (int i = 1; i < N; i++) x_dl[i] <= x_dl[i-1];
    end

    // Direct-form FIR output
    always_comb begin
        y_n = 0;
        for (int i = 0; i < N; i++) y_n += longint'(tap_h[i]) * longint'(x_dl[i]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 4'(a);
        cfg_wr_data = 18'(d);
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (h_n_out !== '0) begin errors++; $display("FAIL reset h_n_out got %0d exp 0", h_n_out); end
        checks++;
        if (h_n_vld !== '0) begin errors++; $display("FAIL reset h_n_vld got %h exp 0", h_n_vld); end
        checks++;
        if ({busy, done, wr_drop} !== 3'b000) begin
            errors++; $display("FAIL reset flags busy/done/wr_drop got %b exp 000", {busy, done, wr_drop});
        end
    endtask

    task automatic test_full_load();
        logic [N-1:0] ev;
        for (int i = 0; i < N; i++) begin
            exp_bank[i] = i * 1000 - 8000;
            wr(i, exp_bank[i]);
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            ev = 16'(1) << k;
            checks++;
            if (h_n_vld !== ev || h_n_out !== 18'(exp_bank[k]) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL full_load k=%0d vld got %h exp %h, data got %0d exp %0d, busy got %b done got %b",
                         k, h_n_vld, ev, h_n_out, exp_bank[k], busy, done);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || h_n_vld !== '0 || h_n_out !== '0) begin
            errors++;
            $display("FAIL full_load_done done got %b exp 1, busy got %b exp 0, vld got %h exp 0, data got %0d exp 0",
                     done, busy, h_n_vld, h_n_out);
        end
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL full_load_done_pulse done got %b exp 0", done); end
    endtask

    task automatic test_extremes();
        exp_bank[0]  = -131072;
        exp_bank[15] = 131071;
        wr(0, exp_bank[0]);
        wr(15, exp_bank[15]);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == 0 || k == 15) begin
                checks++;
                if (h_n_out !== 18'(exp_bank[k]) || h_n_vld[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL extremes k=%0d data got %h exp %h, strobe got %b exp 1",
                             k, h_n_out, 18'(exp_bank[k]), h_n_vld[k]);
                end
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL extremes_done done got %b exp 1", done); end
        step();
    endtask

    task automatic test_busy_reject();
        logic [N-1:0] ev;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            ev = 16'(1) << k;
            checks++;
            if (wr_drop !== (k == 5) || h_n_vld !== ev) begin
                errors++;
                $display("FAIL busy_reject k=%0d wr_drop got %b exp %b, vld got %h exp %h",
                         k, wr_drop, (k == 5), h_n_vld, ev);
            end
            if (k == 4) begin
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = 4'd3;
                cfg_wr_data = 18'sd12345;
                load_start  = 1'b1;
            end else if (k == 5) begin
                cfg_wr_en  = 1'b0;
                load_start = 1'b0;
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL busy_reject_done done got %b exp 1", done); end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (h_n_vld !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_reject_no_second c=%0d vld got %h busy got %b done got %b exp all 0",
                         c, h_n_vld, busy, done);
            end
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == 3) begin
                checks++;
                if (h_n_out !== 18'(exp_bank[3]) || h_n_vld !== 16'h0008) begin
                    errors++;
                    $display("FAIL busy_reject_bank3 data got %0d exp %0d, vld got %h exp 0008",
                             h_n_out, exp_bank[3], h_n_vld);
                end
            end
            step();
        end
        step();
    endtask

    task automatic test_simultaneous();
        exp_bank[0] = 77;
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 4'd0;
        cfg_wr_data = 18'sd77;
        load_start  = 1'b1;
        step();
        cfg_wr_en  = 1'b0;
        load_start = 1'b0;
        checks++;
        if (h_n_out !== 18'sd77 || h_n_vld !== 16'h0001 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous data got %0d exp 77, vld got %h exp 0001, wr_drop got %b exp 0",
                     h_n_out, h_n_vld, wr_drop);
        end
        for (int k = 1; k < N; k++) step();
        step();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL simultaneous_done done got %b exp 1", done); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ev;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < N; k++) step();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL back_to_back_done1 done got %b exp 1", done); end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            ev = 16'(1) << k;
            checks++;
            if (h_n_vld !== ev || h_n_out !== 18'(exp_bank[k]) || busy !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back k=%0d vld got %h exp %h, data got %0d exp %0d, busy got %b",
                         k, h_n_vld, ev, h_n_out, exp_bank[k], busy);
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL back_to_back_done2 done got %b exp 1", done); end
        step();
    endtask

    task automatic test_integration();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k <= N; k++) step();
        x_in = 18'sd1;
        step();
        x_in = '0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (y_n !== longint'(exp_bank[k])) begin
                errors++;
                $display("FAIL integration_impulse k=%0d y got %0d exp %0d", k, y_n, exp_bank[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_midload();
        int old_t10;
        logic [N-1:0] ev;
        old_t10 = exp_bank[10];
        wr(10, 4242);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                rst         = 1'b1;
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = 4'd2;
                cfg_wr_data = 18'sd555;
                load_start  = 1'b1;
            end
            step();
        end
        rst        = 1'b0;
        cfg_wr_en  = 1'b0;
        load_start = 1'b0;
        checks++;
        if (h_n_vld !== '0 || h_n_out !== '0 || busy !== 1'b0 || done !== 1'b0 || wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid vld got %h data got %0d busy %b done %b wr_drop %b exp all 0",
                     h_n_vld, h_n_out, busy, done, wr_drop);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (done !== 1'b0 || h_n_vld !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet c=%0d done got %b vld got %h busy got %b exp all 0",
                         c, done, h_n_vld, busy);
            end
        end
        checks++;
        if (tap_h[10] !== 18'(old_t10) || tap_h[1] !== 18'(exp_bank[1])) begin
            errors++;
            $display("FAIL reset_mid_taps tap10 got %0d exp %0d, tap1 got %0d exp %0d",
                     tap_h[10], old_t10, tap_h[1], exp_bank[1]);
        end
        for (int i = 0; i < N; i++) exp_bank[i] = 0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            ev = 16'(1) << k;
            checks++;
            if (h_n_vld !== ev || h_n_out !== 18'(exp_bank[k])) begin
                errors++;
                $display("FAIL reset_mid_zero k=%0d vld got %h exp %h, data got %0d exp 0",
                         k, h_n_vld, ev, h_n_out);
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL reset_mid_zero_done done got %b exp 1", done); end
        step();
    endtask

    initial begin
        rst         = 1'b1;
        cfg_wr_en   = 1'b0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        load_start  = 1'b0;
        test_reset();
        test_full_load();
        test_extremes();
        test_busy_reject();
        test_simultaneous();
        test_back_to_back();
        test_integration();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
